// File: rtl/seg_scan_mux.sv
// Time-multiplexed 7-segment scanner: hex decode, leading-zero/blank darkening, anode ghost guard.
// segs/dp/anodes are registered one cycle behind the scan state; enable=0 darkens everything at once.
module seg_scan_mux #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD       = 4,
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
  localparam int CW = $clog2(REFRESH_DIV)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic                    lz_en,
  input  logic                    enable,
  output logic [6:0]              segs,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   anodes,
  output logic [IW-1:0]           digit_idx,
  output logic                    frame_tick
);

  logic [CW-1:0]           r_cnt;
  logic [IW-1:0]           r_idx;
  logic [4*NUM_DIGITS-1:0] r_data;
  logic [NUM_DIGITS-1:0]   r_dp_sh;
  logic [NUM_DIGITS-1:0]   r_blank;
  logic [NUM_DIGITS-1:0]   r_anodes;
  logic [6:0]              r_segs;
  logic                    r_dp;
  logic                    r_tick;

  logic                    w_term;
  logic                    w_last;
  logic                    w_guard;
  logic                    w_zero_acc;
  logic                    w_dark;
  logic                    w_dp_cur;
  logic [3:0]              w_nib;
  logic [NUM_DIGITS-1:0]   w_sel;
  logic [NUM_DIGITS-1:0]   w_upper_zero;
  logic [NUM_DIGITS-1:0]   w_dark_vec;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'b0000001;
      4'h1: hex7 = 7'b1001111;
      4'h2: hex7 = 7'b0010010;
      4'h3: hex7 = 7'b0000110;
      4'h4: hex7 = 7'b1001100;
      4'h5: hex7 = 7'b0100100;
      4'h6: hex7 = 7'b0100000;
      4'h7: hex7 = 7'b0001111;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0001100;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b1100000;
      4'hC: hex7 = 7'b0110001;
      4'hD: hex7 = 7'b1000010;
      4'hE: hex7 = 7'b0110000;
      default: hex7 = 7'b0111000;
    endcase
  endfunction

  assign w_term  = (r_cnt == CW'(REFRESH_DIV - 1));
  assign w_last  = (r_idx == IW'(NUM_DIGITS - 1));
  assign w_guard = (int'(r_cnt) < GUARD);

  // w_upper_zero[i]: every nibble from the top digit down to digit i is zero
  always_comb begin
    w_zero_acc   = 1'b1;
    w_upper_zero = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      w_zero_acc      = w_zero_acc & (r_data[4*i +: 4] == 4'h0);
      w_upper_zero[i] = w_zero_acc;
    end
  end

  // digit 0 is excluded from leading-zero suppression so a zero value still shows "0"
  always_comb begin
    w_dark_vec = r_blank;
    for (int i = 1; i < NUM_DIGITS; i++) begin
      w_dark_vec[i] = r_blank[i] | (lz_en & w_upper_zero[i]);
    end
  end

  always_comb begin
    w_nib    = 4'h0;
    w_dark   = 1'b0;
    w_dp_cur = 1'b0;
    w_sel    = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_idx == IW'(i)) begin
        w_nib    = r_data[4*i +: 4];
        w_dark   = w_dark_vec[i];
        w_dp_cur = r_dp_sh[i];
        w_sel[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_idx    <= '0;
      r_data   <= '0;
      r_dp_sh  <= '0;
      r_blank  <= '0;
      r_anodes <= '1;
      r_segs   <= 7'h7f;
      r_dp     <= 1'b1;
      r_tick   <= 1'b0;
    end else begin
      if (load) begin
        r_data  <= data_in;
        r_dp_sh <= dp_in;
        r_blank <= blank_in;
      end
      if (enable) begin
        if (w_term) begin
          r_cnt <= '0;
          r_idx <= w_last ? '0 : r_idx + IW'(1);
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end
      r_tick   <= enable & w_term & w_last;
      r_segs   <= w_dark ? 7'h7f : hex7(w_nib);
      r_dp     <= w_dark | ~w_dp_cur;
      // segments are already driven during the guard so they settle before the anode opens
      r_anodes <= (w_dark | w_guard) ? '1 : ~w_sel;
    end
  end

  assign segs       = enable ? r_segs : 7'h7f;
  assign dp         = enable ? r_dp : 1'b1;
  assign anodes     = enable ? r_anodes : '1;
  assign frame_tick = enable & r_tick;
  assign digit_idx  = r_idx;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Bench for seg_scan_mux (4 digits, 8-cycle slots, 2-cycle guard): directed scenarios plus
// a randomized run against a time-indexed reference model.
module tb_seg_scan_mux;
  localparam int N  = 4;
  localparam int RD = 8;
  localparam int G  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic        lz_en = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] data_in = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  blank_in = '0;
  logic [6:0]  segs;
  logic        dp;
  logic [3:0]  anodes;
  logic [1:0]  digit_idx;
  logic        frame_tick;

  int n_checks = 0;
  int n_fail = 0;

  // model: m_t counts enabled cycles since reset; slot/digit are derived from it arithmetically
  int          m_t;
  logic [15:0] m_data;
  logic [3:0]  m_dp;
  logic [3:0]  m_blank;
  logic [3:0]  e_anodes;
  logic [6:0]  e_segs;
  logic        e_dp;
  logic        e_tick;
  logic [6:0]  seg_tab [16];

  always #5 clk = ~clk;

  seg_scan_mux #(.NUM_DIGITS(N), .REFRESH_DIV(RD), .GUARD(G)) dut (
    .clk(clk), .rst(rst), .load(load), .data_in(data_in), .dp_in(dp_in),
    .blank_in(blank_in), .lz_en(lz_en), .enable(enable), .segs(segs), .dp(dp),
    .anodes(anodes), .digit_idx(digit_idx), .frame_tick(frame_tick)
  );

  task automatic model_reset();
    m_t = 0; m_data = '0; m_dp = '0; m_blank = '0;
    e_anodes = 4'hF; e_segs = 7'h7f; e_dp = 1'b1; e_tick = 1'b0;
  endtask

  // one clock edge; outputs after the edge show the slot/digit/shadow state from before it
  task automatic tick();
    int   cnt;
    int   idx;
    logic dark;
    @(posedge clk);
    cnt  = m_t % RD;
    idx  = (m_t / RD) % N;
    dark = m_blank[idx] || (lz_en && idx > 0 && (m_data >> (4 * idx)) == 16'h0);
    e_segs   = dark ? 7'h7f : seg_tab[m_data[4*idx +: 4]];
    e_dp     = dark ? 1'b1 : ~m_dp[idx];
    e_anodes = (dark || cnt < G) ? 4'hF : ~(4'b0001 << idx);
    e_tick   = enable && cnt == RD - 1 && idx == N - 1;
    if (load) begin
      m_data = data_in; m_dp = dp_in; m_blank = blank_in;
    end
    if (enable) m_t++;
    #1;
  endtask

  function automatic int lit_digit(input logic [3:0] a);
    int d = -1;
    for (int i = 0; i < 4; i++) if (a[i] == 1'b0) d = i;
    return d;
  endfunction

  task automatic test_reset();
    n_checks += 5;
    #3;
    if (anodes !== 4'hF) begin n_fail++; $display("FAIL rst0_anodes got %b want 1111", anodes); end
    if (segs !== 7'h7f) begin n_fail++; $display("FAIL rst0_segs got %b want 1111111", segs); end
    if (dp !== 1'b1) begin n_fail++; $display("FAIL rst0_dp got %b want 1", dp); end
    if (digit_idx !== 2'd0) begin n_fail++; $display("FAIL rst0_idx got %0d want 0", digit_idx); end
    if (frame_tick !== 1'b0) begin n_fail++; $display("FAIL rst0_tick got %b want 0", frame_tick); end
    @(posedge clk); #1;
    rst = 1'b0; enable = 1'b1; model_reset();
    repeat (13) tick();
    rst = 1'b1;
    #2;
    n_checks += 5;
    if (anodes !== 4'hF) begin n_fail++; $display("FAIL midrst_anodes got %b want 1111", anodes); end
    if (segs !== 7'h7f) begin n_fail++; $display("FAIL midrst_segs got %b want 1111111", segs); end
    if (dp !== 1'b1) begin n_fail++; $display("FAIL midrst_dp got %b want 1", dp); end
    if (digit_idx !== 2'd0) begin n_fail++; $display("FAIL midrst_idx got %0d want 0", digit_idx); end
    if (frame_tick !== 1'b0) begin n_fail++; $display("FAIL midrst_tick got %b want 0", frame_tick); end
    @(posedge clk); #1;
    rst = 1'b0; model_reset();
    for (int k = 1; k <= 3; k++) begin
      tick();
      n_checks++;
      if (anodes !== ((k < 3) ? 4'hF : 4'b1110)) begin
        n_fail++; $display("FAIL rel_anodes cyc%0d got %b want %b", k, anodes, (k < 3) ? 4'hF : 4'b1110);
      end
    end
    n_checks += 2;
    if (segs !== 7'b0000001) begin n_fail++; $display("FAIL rel_segs got %b want 0000001", segs); end
    if (digit_idx !== 2'd0) begin n_fail++; $display("FAIL rel_idx got %0d want 0", digit_idx); end
  endtask

  task automatic test_load_scan();
    logic [6:0] exp_seg [4];
    int lit [4];
    int last;
    int nticks;
    int d;
    exp_seg = '{7'b0111000, 7'b0001000, 7'b0010010, 7'b1001111};
    lit = '{0, 0, 0, 0};
    last = -1; nticks = 0;
    data_in = 16'h12AF; dp_in = '0; blank_in = '0; lz_en = 1'b0; enable = 1'b1;
    load = 1'b1; tick(); load = 1'b0; tick();
    for (int c = 0; c < 64; c++) begin
      tick();
      d = lit_digit(anodes);
      if (d >= 0) begin
        lit[d]++;
        n_checks++;
        if (segs !== exp_seg[d]) begin n_fail++; $display("FAIL scan_segs d%0d got %b want %b", d, segs, exp_seg[d]); end
      end
      if (frame_tick === 1'b1) begin
        if (last >= 0) begin
          n_checks++;
          if (c - last != 32) begin n_fail++; $display("FAIL scan_tick_gap got %0d want 32", c - last); end
        end
        last = c; nticks++;
      end
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (lit[i] != 12) begin n_fail++; $display("FAIL scan_lit d%0d got %0d want 12", i, lit[i]); end
    end
    n_checks++;
    if (nticks != 2) begin n_fail++; $display("FAIL scan_ticks got %0d want 2", nticks); end
  endtask

  task automatic test_lz();
    int lit [4];
    int d;
    lit = '{0, 0, 0, 0};
    data_in = 16'h0030; lz_en = 1'b1;
    load = 1'b1; tick(); load = 1'b0; tick();
    for (int c = 0; c < 32; c++) begin
      tick();
      d = lit_digit(anodes);
      if (d >= 0) lit[d]++;
      if (d == 1) begin
        n_checks++;
        if (segs !== 7'b0000110) begin n_fail++; $display("FAIL lz_d1 got %b want 0000110", segs); end
      end
      if (d == 0) begin
        n_checks++;
        if (segs !== 7'b0000001) begin n_fail++; $display("FAIL lz_d0 got %b want 0000001", segs); end
      end
    end
    n_checks += 4;
    if (lit[3] != 0) begin n_fail++; $display("FAIL lz_lit3 got %0d want 0", lit[3]); end
    if (lit[2] != 0) begin n_fail++; $display("FAIL lz_lit2 got %0d want 0", lit[2]); end
    if (lit[1] != 6) begin n_fail++; $display("FAIL lz_lit1 got %0d want 6", lit[1]); end
    if (lit[0] != 6) begin n_fail++; $display("FAIL lz_lit0 got %0d want 6", lit[0]); end
    lit = '{0, 0, 0, 0};
    lz_en = 1'b0; tick();
    for (int c = 0; c < 32; c++) begin
      tick();
      d = lit_digit(anodes);
      if (d >= 0) lit[d]++;
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (lit[i] != 6) begin n_fail++; $display("FAIL nolz_lit d%0d got %0d want 6", i, lit[i]); end
    end
  endtask

  task automatic test_blank_dp();
    int d;
    int a2_on;
    int dp_on;
    int dark_cyc;
    a2_on = 0; dp_on = 0; dark_cyc = 0;
    data_in = 16'h5678; blank_in = 4'b0100; dp_in = 4'b0010;
    load = 1'b1; tick(); load = 1'b0; tick();
    for (int c = 0; c < 32; c++) begin
      tick();
      d = lit_digit(anodes);
      if (anodes[2] === 1'b0) a2_on++;
      if (dp === 1'b0) dp_on++;
      if (segs === 7'h7f) dark_cyc++;
      if (d >= 0) begin
        n_checks++;
        if (dp !== ((d == 1) ? 1'b0 : 1'b1)) begin n_fail++; $display("FAIL bdp_dp d%0d got %b want %b", d, dp, (d == 1) ? 1'b0 : 1'b1); end
      end
    end
    n_checks += 3;
    if (a2_on != 0) begin n_fail++; $display("FAIL bdp_an2 got %0d want 0", a2_on); end
    if (dp_on != 8) begin n_fail++; $display("FAIL bdp_dpcnt got %0d want 8", dp_on); end
    if (dark_cyc != 8) begin n_fail++; $display("FAIL bdp_dark got %0d want 8", dark_cyc); end
    blank_in = '0; dp_in = '0;
    load = 1'b1; tick(); load = 1'b0;
  endtask

  task automatic test_enable_hold();
    for (int k = 0; k < 64 && !((m_t % RD) == 5 && ((m_t / RD) % N) == 2); k++) tick();
    n_checks++;
    if (digit_idx !== 2'd2) begin n_fail++; $display("FAIL hold_pre_idx got %0d want 2", digit_idx); end
    enable = 1'b0;
    #1;
    n_checks++;
    if (anodes !== 4'hF) begin n_fail++; $display("FAIL hold_now_anodes got %b want 1111", anodes); end
    for (int k = 0; k < 10; k++) begin
      tick();
      n_checks += 5;
      if (anodes !== 4'hF) begin n_fail++; $display("FAIL hold_anodes got %b want 1111", anodes); end
      if (segs !== 7'h7f) begin n_fail++; $display("FAIL hold_segs got %b want 1111111", segs); end
      if (dp !== 1'b1) begin n_fail++; $display("FAIL hold_dp got %b want 1", dp); end
      if (frame_tick !== 1'b0) begin n_fail++; $display("FAIL hold_tick got %b want 0", frame_tick); end
      if (digit_idx !== 2'd2) begin n_fail++; $display("FAIL hold_idx got %0d want 2", digit_idx); end
    end
    enable = 1'b1;
    #1;
    n_checks++;
    if (anodes !== 4'b1011) begin n_fail++; $display("FAIL resume_anodes got %b want 1011", anodes); end
    for (int k = 1; k <= 3; k++) begin
      tick();
      n_checks += 2;
      if (frame_tick !== 1'b0) begin n_fail++; $display("FAIL resume_tick got %b want 0", frame_tick); end
      if (digit_idx !== ((k < 3) ? 2'd2 : 2'd3)) begin
        n_fail++; $display("FAIL resume_idx cyc%0d got %0d want %0d", k, digit_idx, (k < 3) ? 2 : 3);
      end
    end
  endtask

  task automatic test_load_terminal();
    data_in = 16'h1234; load = 1'b1; tick(); load = 1'b0; tick();
    for (int k = 0; k < 64 && !((m_t % RD) == 7 && ((m_t / RD) % N) == 1); k++) tick();
    data_in = 16'hABCD; load = 1'b1; tick(); load = 1'b0;
    n_checks += 3;
    if (segs !== 7'b0000110) begin n_fail++; $display("FAIL lterm_old_segs got %b want 0000110", segs); end
    if (anodes !== 4'b1101) begin n_fail++; $display("FAIL lterm_old_anodes got %b want 1101", anodes); end
    if (digit_idx !== 2'd2) begin n_fail++; $display("FAIL lterm_idx got %0d want 2", digit_idx); end
    for (int k = 1; k <= 3; k++) begin
      tick();
      n_checks += 2;
      if (segs !== 7'b1100000) begin n_fail++; $display("FAIL lterm_new_segs cyc%0d got %b want 1100000", k, segs); end
      if (anodes !== ((k < 3) ? 4'hF : 4'b1011)) begin
        n_fail++; $display("FAIL lterm_anodes cyc%0d got %b want %b", k, anodes, (k < 3) ? 4'hF : 4'b1011);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      load = ($urandom_range(0, 7) == 0);
      if (load) begin
        data_in  = 16'($urandom) >> (4 * $urandom_range(0, 4));
        dp_in    = 4'($urandom_range(0, 15));
        blank_in = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
      end
      enable = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 19) == 0) lz_en = ~lz_en;
      tick();
      n_checks += 5;
      if (anodes !== (enable ? e_anodes : 4'hF)) begin
        n_fail++; $display("FAIL rnd_anodes c%0d got %b want %b", c, anodes, enable ? e_anodes : 4'hF);
      end
      if (segs !== (enable ? e_segs : 7'h7f)) begin
        n_fail++; $display("FAIL rnd_segs c%0d got %b want %b", c, segs, enable ? e_segs : 7'h7f);
      end
      if (dp !== (enable ? e_dp : 1'b1)) begin
        n_fail++; $display("FAIL rnd_dp c%0d got %b want %b", c, dp, enable ? e_dp : 1'b1);
      end
      if (frame_tick !== (enable & e_tick)) begin
        n_fail++; $display("FAIL rnd_tick c%0d got %b want %b", c, frame_tick, enable & e_tick);
      end
      if (digit_idx !== 2'((m_t / RD) % N)) begin
        n_fail++; $display("FAIL rnd_idx c%0d got %0d want %0d", c, digit_idx, (m_t / RD) % N);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    seg_tab = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
                7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
    model_reset();
    test_reset();
    test_load_scan();
    test_lz();
    test_blank_dp();
    test_enable_hold();
    test_load_terminal();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
